// File: rtl/ppa_seq_ctrl.sv
// ppa_seq_ctrl: multi-beat add/subtract sequencer driving a shared 16-bit adder one word per cycle
module ppa_seq_ctrl #(
  parameter int WORDS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*WORDS-1:0] op_a,
  input  logic [16*WORDS-1:0] op_b,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] result,
  output logic                carry_out,
  output logic [15:0]         add_a,
  output logic [15:0]         add_b,
  output logic                add_cin,
  input  logic [15:0]         add_sum,
  input  logic                add_cout
);
  localparam int W  = 16*WORDS;
  localparam int CW = WORDS > 1 ? $clog2(WORDS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        st;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_r, b_r;
  logic          carry;
  logic          last;
  assign last      = cnt == CW'(WORDS-1);
  assign in_ready  = st == IDLE;
  assign out_valid = st == DONE;
  assign add_a     = st == RUN ? a_r[{cnt, 4'd0} +: 16] : '0;
  assign add_b     = st == RUN ? b_r[{cnt, 4'd0} +: 16] : '0;
  assign add_cin   = st == RUN ? carry : 1'b0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st        <= IDLE;
      cnt       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      carry     <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
    end else
      case (st)
        IDLE: if (in_valid) begin
          a_r   <= op_a;
          b_r   <= sub ? ~op_b : op_b;
          carry <= sub;
          cnt   <= '0;
          st    <= RUN;
        end
        RUN: begin
          result[{cnt, 4'd0} +: 16] <= add_sum;
          carry <= add_cout;
          cnt   <= last ? '0 : cnt + 1'b1;
          if (last) begin
            st        <= DONE;
            carry_out <= add_cout;
          end
        end
        DONE: if (out_ready) st <= IDLE;
        default: st <= IDLE;
      endcase
endmodule

// File: tb/tb_ppa_seq_ctrl.sv
// tb_ppa_seq_ctrl: randomized and directed checks of ppa_seq_ctrl (WORDS=3) against a whole-word arithmetic model
module tb_ppa_seq_ctrl;
  logic        clk, rst, in_valid, in_ready, sub, out_valid, out_ready, carry_out;
  logic [47:0] op_a, op_b, result;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  int          tests = 0, fails = 0;
  logic        cin_q [8];
  logic [15:0] b_q [8];

  ppa_seq_ctrl #(.WORDS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .carry_out(carry_out),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  // the shared adder the block is meant to drive
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 17'(add_cin);

  always #5 clk = ~clk;

  function automatic logic [48:0] model(input logic [47:0] a, input logic [47:0] b, input logic s);
    model = s ? {a >= b, a - b} : {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [47:0] rnd48();
    int k = $urandom_range(0, 3);
    rnd48 = k == 0 ? 48'h0 : k == 1 ? '1 : 48'({$urandom(), $urandom()});
  endfunction

  // called at a negedge; returns at the first negedge with out_valid=1 (or after a bounded wait)
  task automatic run_op(input logic [47:0] a, input logic [47:0] b, input logic s,
                        output logic [47:0] r, output logic co, output int lat, output logic rdy);
    rdy = in_ready; op_a = a; op_b = b; sub = s; in_valid = 1;
    @(negedge clk);
    in_valid = 0; lat = 0;
    while (!out_valid && lat < 20) begin
      if (lat < 8) begin cin_q[lat] = add_cin; b_q[lat] = add_b; end
      lat++;
      @(negedge clk);
    end
    r = result; co = carry_out;
  endtask

  task automatic drain();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_reset();
    #3;
    tests++;
    if ({out_valid, carry_out, result, add_a, add_b, add_cin} !== '0) begin
      fails++; $display("FAIL reset_outputs: got %h required 0", {out_valid, carry_out, result, add_a, add_b, add_cin});
    end
    tests++;
    if (in_ready !== 1) begin fails++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    @(negedge clk); rst = 0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1) begin fails++; $display("FAIL post_reset_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [47:0] ta [4] = '{48'h0000_0000_FFFF, 48'hFFFF_FFFF_FFFF, 48'h0000_0001_0000, 48'h0};
    logic        ts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [47:0] er [4] = '{48'h0000_0001_0000, 48'h0, 48'h0000_0000_FFFF, 48'hFFFF_FFFF_FFFF};
    logic        ec [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [47:0] r; logic co, rdy; int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], 48'h1, ts[i], r, co, lat, rdy);
      tests++;
      if (r !== er[i] || co !== ec[i]) begin
        fails++; $display("FAIL directed_%0d: got %h/%b required %h/%b", i, r, co, er[i], ec[i]);
      end
      tests++;
      if (lat !== 3) begin fails++; $display("FAIL directed_latency_%0d: got %0d required 3", i, lat); end
      if (i == 1) begin
        tests++;
        if ({cin_q[0], cin_q[1], cin_q[2]} !== 3'b011) begin
          fails++; $display("FAIL carry_chain_cin: got %b required 011", {cin_q[0], cin_q[1], cin_q[2]});
        end
      end
      if (i == 2) begin
        tests++;
        if (b_q[0] !== 16'hFFFE || cin_q[0] !== 1'b1) begin
          fails++; $display("FAIL sub_beat0: got add_b=%h cin=%b required FFFE/1", b_q[0], cin_q[0]);
        end
      end
      drain();
    end
  endtask

  task automatic test_hold();
    logic [47:0] a = rnd48(), b = rnd48(), r; logic s = 1'($urandom), co, rdy; int lat;
    logic [48:0] e = model(a, b, s);
    run_op(a, b, s, r, co, lat, rdy);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid; op_a = rnd48(); op_b = rnd48(); sub = ~sub;
      @(negedge clk);
      tests++;
      if ({out_valid, in_ready, carry_out, result} !== {2'b10, e}) begin
        fails++; $display("FAIL hold_%0d: got v=%b rdy=%b %b/%h required 1/0 %b/%h", i, out_valid, in_ready, carry_out, result, e[48], e[47:0]);
      end
    end
    in_valid = 0;
    drain();
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++; $display("FAIL hold_release: got v=%b rdy=%b required 0/1", out_valid, in_ready);
    end
    tests++;
    if (result !== e[47:0]) begin fails++; $display("FAIL result_retained: got %h required %h", result, e[47:0]); end
  endtask

  task automatic test_reset_abort();
    logic [47:0] r; logic co, rdy; int lat, seen = 0;
    op_a = rnd48(); op_b = rnd48(); sub = 0; in_valid = 1;
    @(negedge clk); in_valid = 0;
    @(negedge clk);
    rst = 1;
    #1;
    tests++;
    if ({out_valid, add_a, add_b, add_cin, in_ready} !== 35'h1) begin
      fails++; $display("FAIL async_reset: got v=%b a=%h b=%h cin=%b rdy=%b required 0/0/0/0/1", out_valid, add_a, add_b, add_cin, in_ready);
    end
    @(negedge clk); rst = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL aborted_out_valid: got %0d cycles required 0", seen); end
    run_op(48'h1234_5678_9ABC, 48'h1111_1111_1111, 1'b0, r, co, lat, rdy);
    tests++;
    if (r !== 48'h2345_6789_ABCD || co !== 1'b0 || lat !== 3) begin
      fails++; $display("FAIL after_abort: got %h/%b lat %0d required 23456789ABCD/0 lat 3", r, co, lat);
    end
    drain();
  endtask

  task automatic test_random();
    logic [47:0] a, b, r; logic s, co, rdy; int lat; logic [48:0] e;
    for (int i = 0; i < 40; i++) begin
      a = rnd48(); b = rnd48(); s = 1'($urandom); e = model(a, b, s);
      out_ready = 1'($urandom);
      run_op(a, b, s, r, co, lat, rdy);
      tests++;
      if ({co, r} !== e || lat !== 3 || rdy !== 1) begin
        fails++; $display("FAIL random_%0d: %h %s %h got %b/%h lat %0d rdy %b required %b/%h lat 3 rdy 1",
                          i, a, s ? "-" : "+", b, co, r, lat, rdy, e[48], e[47:0]);
      end
      drain();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] a, b, r; logic s, co, rdy; int lat; logic [48:0] e;
    for (int i = 0; i < 4; i++) begin
      a = rnd48(); b = rnd48(); s = 1'(i); e = model(a, b, s);
      run_op(a, b, s, r, co, lat, rdy);
      tests++;
      if ({co, r} !== e || rdy !== 1 || lat !== 3) begin
        fails++; $display("FAIL back_to_back_%0d: got %b/%h rdy %b lat %0d required %b/%h rdy 1 lat 3", i, co, r, rdy, lat, e[48], e[47:0]);
      end
      drain();
    end
  endtask

  initial begin
    clk = 0; rst = 1; in_valid = 0; op_a = 0; op_b = 0; sub = 0; out_ready = 0;
    test_reset();
    test_directed();
    test_hold();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
